// File: rtl/serial_full_subtractor.sv
// ============================================================================
//  Module      : serial_full_subtractor
//  Description : Bit-serial a - b (LSB first) using one full-subtractor cell
//                and a borrow flip-flop. Define SERIAL_SUB_OVF_EN to add the
//                signed-overflow output port ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_diff_sr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_borrow_ff;

    logic w_x;
    logic w_y;
    logic w_d;
    logic w_borrow_next;

    // Full-subtractor cell operating on the current LSBs and the held borrow.
    assign w_x           = r_a_sr[0];
    assign w_y           = r_b_sr[0];
    assign w_d           = w_x ^ w_y ^ r_borrow_ff;
    assign w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow_ff);

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic w_ovf_next;

    // The final d is the result MSB, so overflow resolves on the last bit.
    assign w_ovf_next = (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_diff_sr   <= '0;
            r_count     <= '0;
            r_borrow_ff <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            diff        <= '0;
            borrow      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            ovf         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_SHIFT;
                        r_a_sr      <= a;
                        r_b_sr      <= b;
                        r_diff_sr   <= '0;
                        r_count     <= '0;
                        r_borrow_ff <= 1'b0;
                        busy        <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb     <= a[WIDTH-1];
                        r_b_msb     <= b[WIDTH-1];
`endif
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end

                S_SHIFT: begin
                    r_a_sr      <= r_a_sr >> 1;
                    r_b_sr      <= r_b_sr >> 1;
                    r_diff_sr   <= {w_d, r_diff_sr[WIDTH-1:1]};
                    r_borrow_ff <= w_borrow_next;
                    r_count     <= r_count + 1'b1;
                    // Publish only the complete result, on the final bit.
                    if (r_count == c_LAST) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        diff    <= {w_d, r_diff_sr[WIDTH-1:1]};
                        borrow  <= w_borrow_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf     <= w_ovf_next;
`endif
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
